// File: rtl/rv_decode_stage.sv
// RV32I decode stage: combinational decode into the control bundle, one pipeline
// register with valid/ready flow control, load-use bubble insertion and flush.
module rv_decode_stage #(
    parameter int PC_W      = 32,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_branch,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_mem_to_reg,
    output logic             out_reg_write,
    output logic [2:0]       out_mem_op,
    output logic [3:0]       out_alu_op,
    output logic [2:0]       out_alu_src,
    output logic [2:0]       out_imm_op,
    output logic             out_illegal,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam bit HZ_ON = (HAZARD_EN != 0);

    localparam logic [4:0] KEY_R      = 5'b01100;
    localparam logic [4:0] KEY_IALU   = 5'b00100;
    localparam logic [4:0] KEY_LOAD   = 5'b00000;
    localparam logic [4:0] KEY_STORE  = 5'b01000;
    localparam logic [4:0] KEY_BRANCH = 5'b11000;
    localparam logic [4:0] KEY_JAL    = 5'b11011;
    localparam logic [4:0] KEY_JALR   = 5'b11001;
    localparam logic [4:0] KEY_LUI    = 5'b01101;
    localparam logic [4:0] KEY_AUIPC  = 5'b00101;
    localparam logic [4:0] KEY_FENCE  = 5'b00011;
    localparam logic [4:0] KEY_SYSTEM = 5'b11100;

    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_S = 3'b011;
    localparam logic [2:0] IMM_B = 3'b100;
    localparam logic [2:0] IMM_J = 3'b101;

    // funct3 lines up with the alu_op low bits except sltu, which is remapped.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        if (f3 == 3'b011)
            return 4'b1010;
        return {alt, f3};
    endfunction

    logic [4:0] key;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;
    assign key = in_inst[6:2];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];
    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];
    assign rd  = in_inst[11:7];

    logic       legal, uses_rs1, uses_rs2;
    logic [2:0] d_branch, d_mem_op, d_alu_src, d_imm_op;
    logic [3:0] d_alu_op;
    logic       d_mem_read, d_mem_write, d_mem_to_reg, d_reg_write;

    always_comb begin
        legal        = 1'b1;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        d_branch     = 3'b000;
        d_mem_op     = 3'b000;
        d_alu_src    = 3'b000;
        d_imm_op     = 3'b000;
        d_alu_op     = 4'b0000;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_reg_write  = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            legal = 1'b0;
        end else begin
            case (key)
                KEY_R: begin
                    legal       = (f7 == 7'b0000000) ||
                                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                    d_alu_op    = alu_from_f3(f3, f7[5]);
                    d_reg_write = 1'b1;
                    uses_rs1    = 1'b1;
                    uses_rs2    = 1'b1;
                end
                KEY_IALU: begin
                    d_alu_src   = 3'b010;
                    d_imm_op    = IMM_I;
                    d_reg_write = 1'b1;
                    uses_rs1    = 1'b1;
                    d_alu_op    = alu_from_f3(f3, 1'b0);
                    if (f3 == 3'b001) begin
                        legal = (f7 == 7'b0000000);
                    end else if (f3 == 3'b101) begin
                        legal    = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                        d_alu_op = alu_from_f3(f3, f7[5]);
                    end
                end
                KEY_LOAD: begin
                    legal        = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                    d_alu_src    = 3'b010;
                    d_imm_op     = IMM_I;
                    d_mem_read   = 1'b1;
                    d_mem_to_reg = 1'b1;
                    d_reg_write  = 1'b1;
                    d_mem_op     = f3;
                    uses_rs1     = 1'b1;
                end
                KEY_STORE: begin
                    legal       = !f3[2] && (f3 != 3'b011);
                    d_alu_src   = 3'b010;
                    d_imm_op    = IMM_S;
                    d_mem_write = 1'b1;
                    d_mem_op    = f3;
                    uses_rs1    = 1'b1;
                    uses_rs2    = 1'b1;
                end
                KEY_BRANCH: begin
                    // funct3[1] selects the unsigned compares, funct3[2]/[0] pick lt/ge and eq/ne.
                    legal    = (f3[2:1] != 2'b01);
                    d_imm_op = IMM_B;
                    d_branch = {1'b1, f3[2], f3[0]};
                    d_alu_op = f3[1] ? 4'b1010 : 4'b1000;
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                end
                KEY_JAL: begin
                    d_alu_src   = 3'b101;
                    d_imm_op    = IMM_J;
                    d_branch    = 3'b001;
                    d_reg_write = 1'b1;
                end
                KEY_JALR: begin
                    legal       = (f3 == 3'b000);
                    d_alu_src   = 3'b101;
                    d_imm_op    = IMM_I;
                    d_branch    = 3'b010;
                    d_reg_write = 1'b1;
                    uses_rs1    = 1'b1;
                end
                KEY_LUI: begin
                    d_alu_op    = 4'b0011;
                    d_alu_src   = 3'b010;
                    d_imm_op    = IMM_U;
                    d_reg_write = 1'b1;
                end
                KEY_AUIPC: begin
                    d_alu_src   = 3'b011;
                    d_imm_op    = IMM_U;
                    d_reg_write = 1'b1;
                end
                KEY_FENCE, KEY_SYSTEM: ;
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin
            uses_rs1     = 1'b0;
            uses_rs2     = 1'b0;
            d_branch     = 3'b000;
            d_mem_op     = 3'b000;
            d_alu_src    = 3'b000;
            d_imm_op     = 3'b000;
            d_alu_op     = 4'b0000;
            d_mem_read   = 1'b0;
            d_mem_write  = 1'b0;
            d_mem_to_reg = 1'b0;
            d_reg_write  = 1'b0;
        end
        if (rd == 5'd0)
            d_reg_write = 1'b0;
    end

    logic             vld_p1, mem_read_p1, mem_write_p1, mem_to_reg_p1, reg_write_p1, illegal_p1;
    logic [PC_W-1:0]  pc_p1;
    logic [4:0]       rs1_p1, rs2_p1, rd_p1;
    logic [2:0]       branch_p1, mem_op_p1, alu_src_p1, imm_op_p1;
    logic [3:0]       alu_op_p1;
    logic [CNT_W-1:0] bubble_cnt_p1;

    logic adv, hz;
    assign adv = !vld_p1 || out_ready;
    assign hz  = HZ_ON && in_valid && vld_p1 && mem_read_p1 && (rd_p1 != 5'd0) &&
                 ((uses_rs1 && rs1 == rd_p1) || (uses_rs2 && rs2 == rd_p1));
    assign in_ready = flush || (adv && !hz);

    // decode -> execute register; the write-enables are cleared whenever the slot empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            pc_p1         <= '0;
            rs1_p1        <= '0;
            rs2_p1        <= '0;
            rd_p1         <= '0;
            branch_p1     <= '0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_op_p1     <= '0;
            alu_op_p1     <= '0;
            alu_src_p1    <= '0;
            imm_op_p1     <= '0;
            illegal_p1    <= 1'b0;
            bubble_cnt_p1 <= '0;
        end else if (flush || adv) begin
            if (!flush && hz && bubble_cnt_p1 != '1)
                bubble_cnt_p1 <= bubble_cnt_p1 + CNT_W'(1);
            if (!flush && !hz && in_valid) begin
                vld_p1        <= 1'b1;
                pc_p1         <= in_pc;
                rs1_p1        <= rs1;
                rs2_p1        <= rs2;
                rd_p1         <= rd;
                branch_p1     <= d_branch;
                mem_read_p1   <= d_mem_read;
                mem_write_p1  <= d_mem_write;
                mem_to_reg_p1 <= d_mem_to_reg;
                reg_write_p1  <= d_reg_write;
                mem_op_p1     <= d_mem_op;
                alu_op_p1     <= d_alu_op;
                alu_src_p1    <= d_alu_src;
                imm_op_p1     <= d_imm_op;
                illegal_p1    <= !legal;
            end else begin
                vld_p1       <= 1'b0;
                mem_read_p1  <= 1'b0;
                mem_write_p1 <= 1'b0;
                reg_write_p1 <= 1'b0;
            end
        end
    end

    assign out_valid      = vld_p1;
    assign out_pc         = pc_p1;
    assign out_rs1        = rs1_p1;
    assign out_rs2        = rs2_p1;
    assign out_rd         = rd_p1;
    assign out_branch     = branch_p1;
    assign out_mem_read   = mem_read_p1;
    assign out_mem_write  = mem_write_p1;
    assign out_mem_to_reg = mem_to_reg_p1;
    assign out_reg_write  = reg_write_p1;
    assign out_mem_op     = mem_op_p1;
    assign out_alu_op     = alu_op_p1;
    assign out_alu_src    = alu_src_p1;
    assign out_imm_op     = imm_op_p1;
    assign out_illegal    = illegal_p1;
    assign bubble_cnt     = bubble_cnt_p1;
endmodule
